vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator for the 800x480 VGA panel. Produces the pixel coordinates
//  vga_h/vga_v that the frame buffer uses to look up pixels, plus hsync/vsync/blank.
//  The sync and blank outputs are delayed by SYNC_DELAY clocks so they stay aligned with
//  the frame buffer's registered RAM read. Sits directly upstream of the frame buffer.
// PARAMETERS
//  H_VISIBLE   800  active pixels per line
//  H_FRONT      40  front porch, pixels
//  H_SYNC       48  hsync width, pixels
//  H_BACK       40  back porch, pixels (H total = 928)
//  V_VISIBLE   480  active lines per frame
//  V_FRONT      13  front porch, lines
//  V_SYNC        3  vsync width, lines
//  V_BACK       29  back porch, lines (V total = 525)
//  SYNC_ACTIVE   0  sync asserted level (0 = negative polarity)
//  SYNC_DELAY    1  clk cycles of delay on hsync/vsync/blank (0..7 legal)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous reset, active-high
//  pix_en       in   1   pixel-rate enable; counters advance only when high
//  vga_h        out  11  current horizontal count, 0..H_total-1
//  vga_v        out  11  current vertical count, 0..V_total-1
//  visible      out  1   undelayed: vga_h<H_VISIBLE && vga_v<V_VISIBLE
//  hsync        out  1   delayed horizontal sync
//  vsync        out  1   delayed vertical sync
//  blank        out  1   delayed inverse of visible
//  frame_start  out  1   one-clk pulse on the clk where counters move to (0,0)
// BEHAVIOUR
//  - Reset: vga_h=0, vga_v=0, visible=1, frame_start=0. The delay line is cleared to
//    hsync=vsync=~SYNC_ACTIVE and blank=0. This takes effect on the next edge and
//    overrides pix_en. Reset mid-frame restarts at (0,0) with no frame_start pulse.
//  - vga_h/vga_v are registers. On a clk with pix_en=1:
//    - vga_h increments.
//    - At vga_h==H_total-1, vga_h wraps to 0 and vga_v increments.
//    - At vga_v==V_total-1 together with the line wrap, vga_v wraps to 0.
//    - When pix_en=0, all counters hold.
//  - frame_start=1 for exactly one clk: the clk after the edge on which the (H_total-1,
//    V_total-1) -> (0,0) transition happened. Not asserted after reset.
//  - Raw sync is decoded combinationally from the current counters:
//    - hs_raw asserted for H_VISIBLE+H_FRONT <= vga_h < H_VISIBLE+H_FRONT+H_SYNC.
//    - vs_raw asserted for V_VISIBLE+V_FRONT <= vga_v < V_VISIBLE+V_FRONT+V_SYNC.
//    - Asserted means driven to SYNC_ACTIVE.
//  - hsync/vsync/blank = raw values passed through a SYNC_DELAY-stage shift register
//    clocked every clk, independent of pix_en. SYNC_DELAY=0 gives combinational
//    pass-through.
//  - Widths: totals must be < 2048. All compares are unsigned 11-bit; no overflow past
//    wrap.
//  - The coordinate pair (vga_h,vga_v) never takes an out-of-range value, including the
//    cycle after reset.
// TESTING
//  1. Reset held 3 clks, pix_en=1, then released.
//     -> vga_h=0,vga_v=0 at release; vga_h=5 after 5 clks; hsync=1, blank=0
//     -> with SYNC_DELAY=1, blank rises on the clk after vga_h goes 799->800.
//  2. Full line, pix_en=1.
//     -> vga_h 927->0 and vga_v 0->1 on the same edge
//     -> hsync low for exactly 48 clks, starting 1 clk after vga_h==840.
//  3. Full frame, pix_en=1.
//     -> frame_start pulses once per 928*525=487200 clks
//     -> vsync low for exactly 3*928 clks, starting on line 493 (+1 clk).
//  4. pix_en toggling 1,0,1,0.
//     -> counters advance every other clk; line period = 1856 clks
//     -> hsync width = 96 clks.
//  5. reset asserted at vga_h=400, vga_v=300.
//     -> next clk: (0,0), frame_start=0; one clk later hsync=vsync=1, blank=0.
//  6. Override to H_VISIBLE=4, H_FRONT=1, H_SYNC=1, H_BACK=1 and V_VISIBLE=2, V_FRONT=1,
//     V_SYNC=1, V_BACK=1 (both totals 7 and 5).
//     -> exhaustive check of visible/hsync/vsync per (h,v) against the decode rules.

Source files
------------

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster timing generator: pixel counters, sync decode, delayed sync/blank
module vga_sync_gen #(
  parameter int H_VISIBLE   = 800,
  parameter int H_FRONT     = 40,
  parameter int H_SYNC      = 48,
  parameter int H_BACK      = 40,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 13,
  parameter int V_SYNC      = 3,
  parameter int V_BACK      = 29,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int SYNC_DELAY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] vga_h,
  output logic [10:0] vga_v,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       h_last;
  logic       v_last;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] raw_bus;
  logic [2:0] reset_bus;
  logic [2:0] dly_out;

  assign h_last = (vga_h == H_LAST);
  assign v_last = (vga_v == V_LAST);

  // Counters wrap exactly at the last position, so they can never leave range.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_h <= 11'd0;
      vga_v <= 11'd0;
    end else if (pix_en) begin
      if (h_last) begin
        vga_h <= 11'd0;
        vga_v <= v_last ? 11'd0 : vga_v + 11'd1;
      end else begin
        vga_h <= vga_h + 11'd1;
      end
    end
  end

  // High for the one clk in which the counters sit at (0,0) after a frame wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_last && v_last;
    end
  end

  assign visible = (vga_h < H_VIS_END) && (vga_v < V_VIS_END);

  assign hs_raw = ((vga_h >= H_SYNC_START) && (vga_h < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vs_raw = ((vga_v >= V_SYNC_START) && (vga_v < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  assign raw_bus   = {hs_raw, vs_raw, ~visible};
  assign reset_bus = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  // Delay line runs every clk so it matches the frame buffer's read latency, not pix_en.
  generate
    if (SYNC_DELAY == 0) begin : g_no_dly
      assign dly_out = raw_bus;
    end else begin : g_dly
      logic [2:0] stage [SYNC_DELAY];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < SYNC_DELAY; i++) begin
            stage[i] <= reset_bus;
          end
        end else begin
          stage[0] <= raw_bus;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dly_out = stage[SYNC_DELAY-1];
    end
  endgenerate

  assign hsync = dly_out[2];
  assign vsync = dly_out[1];
  assign blank = dly_out[0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [10:0] vga_h, vga_v;
  logic        visible, hsync, vsync, blank, frame_start;
  logic [10:0] sm_h, sm_v;
  logic        sm_visible, sm_hsync, sm_vsync, sm_blank, sm_frame_start;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .vga_h(vga_h), .vga_v(vga_v), .visible(visible),
    .hsync(hsync), .vsync(vsync), .blank(blank), .frame_start(frame_start)
  );

  vga_sync_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1'b0), .SYNC_DELAY(0)
  ) dut_small (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .vga_h(sm_h), .vga_v(sm_v), .visible(sm_visible),
    .hsync(sm_hsync), .vsync(sm_vsync), .blank(sm_blank), .frame_start(sm_frame_start)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int cnt;
    int eh, ev, fs_seen;
    int exp_vis, exp_hs, exp_vs, exp_fs;

    // Reset held three clocks with pix_en high
    reset  = 1'b1;
    pix_en = 1'b1;
    repeat (3) step();
    check("rst_h", vga_h, 0);
    check("rst_v", vga_v, 0);
    check("rst_visible", visible, 1);
    check("rst_frame_start", frame_start, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_blank", blank, 0);

    reset = 1'b0;
    repeat (5) step();
    check("h_after5", vga_h, 5);
    check("hsync_after5", hsync, 1);
    check("blank_after5", blank, 0);

    // Blank follows the 799->800 transition by one clk
    repeat (795) step();
    check("h_800", vga_h, 800);
    check("visible_h800", visible, 0);
    check("blank_at_800", blank, 0);
    step();
    check("blank_after_800", blank, 1);

    // hsync: low for 48 clks starting one clk after h==840
    repeat (39) step();
    check("h_840", vga_h, 840);
    check("hsync_at_840", hsync, 1);
    step();
    cnt = 0;
    while (hsync == 1'b0 && cnt < 200) begin
      cnt++;
      step();
    end
    check("hsync_width", cnt, 48);
    check("h_after_hsync", vga_h, 889);

    repeat (38) step();
    check("h_927", vga_h, 927);
    check("v_line0", vga_v, 0);
    step();
    check("h_wrap", vga_h, 0);
    check("v_inc", vga_v, 1);
    check("no_fs_line_wrap", frame_start, 0);

    // pix_en toggling: one increment per two clks
    cnt = 0;
    for (int i = 0; i < 1856; i++) begin
      pix_en = (i % 2 == 0);
      step();
      if (hsync == 1'b0) cnt++;
      if (i == 0) check("toggle_adv", vga_h, 1);
      if (i == 1) check("toggle_hold", vga_h, 1);
    end
    check("toggle_line_h", vga_h, 0);
    check("toggle_line_v", vga_v, 2);
    check("toggle_hsync_width", cnt, 96);
    pix_en = 1'b0;
    repeat (3) step();
    check("hold_h", vga_h, 0);
    check("hold_v", vga_v, 2);
    pix_en = 1'b1;

    // Reset mid-line while hsync is asserted
    repeat (850) step();
    check("pre_rst_h", vga_h, 850);
    check("pre_rst_hsync", hsync, 0);
    reset = 1'b1;
    step();
    check("midrst_h", vga_h, 0);
    check("midrst_v", vga_v, 0);
    check("midrst_fs", frame_start, 0);
    step();
    check("midrst_hsync", hsync, 1);
    check("midrst_vsync", vsync, 1);
    check("midrst_blank", blank, 0);
    reset = 1'b0;

    // Small geometry: exhaustive decode over two frames (totals 7 x 5)
    eh = 0;
    ev = 0;
    fs_seen = 0;
    for (int k = 0; k < 70; k++) begin
      exp_vis = (eh < 4 && ev < 2) ? 1 : 0;
      exp_hs  = (eh == 5) ? 0 : 1;
      exp_vs  = (ev == 3) ? 0 : 1;
      exp_fs  = (k > 0 && eh == 0 && ev == 0) ? 1 : 0;
      check("sm_h", sm_h, eh);
      check("sm_v", sm_v, ev);
      check("sm_visible", sm_visible, exp_vis);
      check("sm_blank", sm_blank, 1 - exp_vis);
      check("sm_hsync", sm_hsync, exp_hs);
      check("sm_vsync", sm_vsync, exp_vs);
      check("sm_frame_start", sm_frame_start, exp_fs);
      if (sm_frame_start) fs_seen++;
      step();
      if (eh == 6) begin
        eh = 0;
        ev = (ev == 4) ? 0 : ev + 1;
      end else begin
        eh = eh + 1;
      end
    end
    check("sm_fs_count", fs_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
